// File: rtl/pattern_scan_arb.sv
// pattern_scan_arb: two-requester round-robin scheduler sharing one serial
// Moore "10110" overlapping detector. Each requester keeps its own saved
// detector context, so a pattern that spans two words of the same stream is
// still found. Other requesters' traffic does not affect that saved context.
module pattern_scan_arb #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   input  logic             clr,
   output logic             busy,
   output logic             grant_id,
   output logic             det_bit,
   output logic             det_match,
   output logic             done_valid,
   output logic             done_id,
   output logic [CNT_W-1:0] done_hits,
   output logic [CNT_W-1:0] match_cnt0,
   output logic [CNT_W-1:0] match_cnt1
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_SHIFT,
      CTRL_DONE
   } ctrl_t;

   // S5 means "10110" has just been seen.
   typedef enum logic [2:0] {
      S0,
      S1,
      S2,
      S3,
      S4,
      S5
   } det_t;

   // Detector transition table. S5 on input 1 goes to S3, which keeps the
   // overlapping "10" tail alive for the next match.
   function automatic det_t det_next(input det_t cur, input logic b);
      det_t nxt;
      nxt = S0;
      case (cur)
         S0:      nxt = b ? S1 : S0;
         S1:      nxt = b ? S1 : S2;
         S2:      nxt = b ? S3 : S0;
         S3:      nxt = b ? S4 : S2;
         S4:      nxt = b ? S1 : S5;
         S5:      nxt = b ? S3 : S0;
         default: nxt = S0;
      endcase
      return nxt;
   endfunction

   ctrl_t            ctrl_q, ctrl_d;
   det_t             det_q, det_d;
   det_t             ctx0_q, ctx0_d;
   det_t             ctx1_q, ctx1_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0] hits_q, hits_d;
   logic             grant_id_q, grant_id_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] match_cnt0_q, match_cnt0_d;
   logic [CNT_W-1:0] match_cnt1_q, match_cnt1_d;

   logic             winner;
   logic             accept;
   det_t             det_step;
   logic [CNT_W:0]   total_sum;
   logic [CNT_W-1:0] total_sat;

   // Round-robin pick: with both requesters valid, the one not served last
   // wins; a lone valid requester always wins.
   always_comb begin
      winner = 1'b0;
      if (req0_valid && req1_valid) begin
         winner = ~last_grant_q;
      end else if (req1_valid) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end
   end

   // Handshake is only offered in IDLE and never while a clear is pending.
   assign accept     = (ctrl_q == CTRL_IDLE) && !clr && (req0_valid || req1_valid);
   assign req0_ready = accept && !winner;
   assign req1_ready = accept && winner;

   // Saturating add of this word's hits into the granted requester's total.
   always_comb begin
      total_sum = '0;
      total_sat = '0;
      if (grant_id_q) begin
         total_sum = {1'b0, match_cnt1_q} + {1'b0, hits_q};
      end else begin
         total_sum = {1'b0, match_cnt0_q} + {1'b0, hits_q};
      end
      total_sat = total_sum[CNT_W] ? CNT_MAX : total_sum[CNT_W-1:0];
   end

   // Control FSM, detector stepping, context save/restore and counters.
   always_comb begin
      ctrl_d       = ctrl_q;
      det_d        = det_q;
      ctx0_d       = ctx0_q;
      ctx1_d       = ctx1_q;
      word_d       = word_q;
      bit_idx_d    = bit_idx_q;
      hits_d       = hits_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      match_cnt0_d = match_cnt0_q;
      match_cnt1_d = match_cnt1_q;
      det_step     = det_next(det_q, word_q[WIDTH-1]);

      if (clr) begin
         ctrl_d       = CTRL_IDLE;
         det_d        = S0;
         ctx0_d       = S0;
         ctx1_d       = S0;
         word_d       = '0;
         bit_idx_d    = '0;
         hits_d       = '0;
         grant_id_d   = 1'b0;
         last_grant_d = 1'b1;
         match_cnt0_d = '0;
         match_cnt1_d = '0;
      end else begin
         case (ctrl_q)
            CTRL_IDLE: begin
               if (accept) begin
                  word_d       = winner ? req1_data : req0_data;
                  grant_id_d   = winner;
                  last_grant_d = winner;
                  det_d        = winner ? ctx1_q : ctx0_q;
                  hits_d       = '0;
                  bit_idx_d    = '0;
                  ctrl_d       = CTRL_SHIFT;
               end
            end
            CTRL_SHIFT: begin
               det_d     = det_step;
               word_d    = {word_q[WIDTH-2:0], 1'b0};
               bit_idx_d = bit_idx_q + BIT_W'(1);
               if ((det_step == S5) && (hits_q != CNT_MAX)) begin
                  hits_d = hits_q + CNT_W'(1);
               end
               if (bit_idx_q == LAST_BIT) begin
                  ctrl_d = CTRL_DONE;
               end
            end
            CTRL_DONE: begin
               if (grant_id_q) begin
                  ctx1_d       = det_q;
                  match_cnt1_d = total_sat;
               end else begin
                  ctx0_d       = det_q;
                  match_cnt0_d = total_sat;
               end
               ctrl_d = CTRL_IDLE;
            end
            default: begin
               ctrl_d = CTRL_IDLE;
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q       <= CTRL_IDLE;
         det_q        <= S0;
         ctx0_q       <= S0;
         ctx1_q       <= S0;
         word_q       <= '0;
         bit_idx_q    <= '0;
         hits_q       <= '0;
         grant_id_q   <= 1'b0;
         last_grant_q <= 1'b1;
         match_cnt0_q <= '0;
         match_cnt1_q <= '0;
      end else begin
         ctrl_q       <= ctrl_d;
         det_q        <= det_d;
         ctx0_q       <= ctx0_d;
         ctx1_q       <= ctx1_d;
         word_q       <= word_d;
         bit_idx_q    <= bit_idx_d;
         hits_q       <= hits_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         match_cnt0_q <= match_cnt0_d;
         match_cnt1_q <= match_cnt1_d;
      end
   end

   assign busy       = (ctrl_q != CTRL_IDLE);
   assign grant_id   = grant_id_q;
   assign det_bit    = (ctrl_q == CTRL_SHIFT) && word_q[WIDTH-1];
   assign det_match  = (det_q == S5);
   assign done_valid = (ctrl_q == CTRL_DONE) && !clr;
   assign done_id    = grant_id_q;
   assign done_hits  = hits_q;
   assign match_cnt0 = match_cnt0_q;
   assign match_cnt1 = match_cnt1_q;

endmodule

// File: tb/tb_pattern_scan_arb.sv
// Scoreboard bench for pattern_scan_arb: directed words with hand-computed
// hit counts. A second instance with CNT_W=2 shares the stimulus and is used
// for the saturation case.
module tb_pattern_scan_arb;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0_valid = 1'b0;
   logic       req1_valid = 1'b0;
   logic [W-1:0] req0_data = '0;
   logic [W-1:0] req1_data = '0;
   logic       clr = 1'b0;

   logic       req0_ready, req1_ready, busy, grant_id, det_bit, det_match;
   logic       done_valid, done_id;
   logic [7:0] done_hits, match_cnt0, match_cnt1;

   logic       s_req0_ready, s_req1_ready, s_busy, s_grant_id, s_det_bit, s_det_match;
   logic       s_done_valid, s_done_id;
   logic [1:0] s_done_hits, s_match_cnt0, s_match_cnt1;

   typedef struct {
      bit id;
      int hits;
      int total;
      int acceptCyc;
   } exp_t;

   exp_t sbQ[$];
   exp_t mEnt;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   doneCount = 0;
   bit   pendChk = 0;
   bit   pendId = 0;
   int   pendTotal = 0;

   pattern_scan_arb #(.WIDTH(W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .clr(clr), .busy(busy), .grant_id(grant_id), .det_bit(det_bit),
      .det_match(det_match), .done_valid(done_valid), .done_id(done_id),
      .done_hits(done_hits), .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
   );

   pattern_scan_arb #(.WIDTH(W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
      .clr(clr), .busy(s_busy), .grant_id(s_grant_id), .det_bit(s_det_bit),
      .det_match(s_det_match), .done_valid(s_done_valid), .done_id(s_done_id),
      .done_hits(s_done_hits), .match_cnt0(s_match_cnt0), .match_cnt1(s_match_cnt1)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per done pulse, then checks the running
   // total one cycle later when it becomes visible.
   always @(negedge clk) begin
      if (pendChk) begin
         checkOutput("match_cnt_total", pendId ? match_cnt1 : match_cnt0, pendTotal);
         pendChk = 0;
      end
      if (rst && done_valid) begin
         doneCount++;
         if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done_id %0d hits %0d expected no done", done_id, done_hits);
         end else begin
            mEnt = sbQ.pop_front();
            checkOutput("done_id", done_id, mEnt.id);
            checkOutput("done_hits", done_hits, mEnt.hits);
            checkOutput("done_latency", cyc - mEnt.acceptCyc, W + 1);
            pendChk   = 1;
            pendId    = mEnt.id;
            pendTotal = mEnt.total;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the first SHIFT cycle.
   task automatic applyStimulus(input bit id, input logic [W-1:0] data, input bit expectDone,
                                input int expHits, input int expTotal);
      int waitCnt;
      exp_t ent;
      waitCnt = 0;
      if (id) begin req1_valid = 1'b1; req1_data = data; end
      else    begin req0_valid = 1'b1; req0_data = data; end
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && waitCnt < 50) begin
         @(negedge clk);
         waitCnt++;
      end
      checks++;
      if (waitCnt >= 50) begin
         failures++;
         $display("[TB] FAIL accept_timeout: got no ready for req%0d expected ready", id);
      end else if (expectDone) begin
         ent.id = id; ent.hits = expHits; ent.total = expTotal; ent.acceptCyc = cyc;
         sbQ.push_back(ent);
      end
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_reached", busy, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic clrPulse();
      clr = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      checkOutput("ready_during_clr", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      clr = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checkOutput("clr_match_cnt0", match_cnt0, 0);
      checkOutput("clr_match_cnt1", match_cnt1, 0);
      checkOutput("clr_busy_det", {busy, det_match}, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] w1;
      logic [8:0]   expMatch;
      int           nAcc, guard, prevCyc, dc;

      // Reset and idle
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset_outputs", {req0_ready, req1_ready, busy, grant_id, det_bit, det_match, done_valid, done_id}, 0);
      checkOutput("reset_counts", {done_hits, match_cnt0, match_cnt1}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("idle_outputs", {req0_ready, req1_ready, busy, grant_id, det_bit, det_match, done_valid, done_id}, 0);
      checkOutput("idle_counts", {done_hits, match_cnt0, match_cnt1}, 0);
      @(posedge clk); #1;

      // Single word with two overlapping hits
      w1       = 8'b10110110;
      expMatch = 9'b100100000;
      applyStimulus(1'b0, w1, 1'b1, 2, 2);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k < 8) checkOutput("det_bit", det_bit, w1[7-k]);
         checkOutput("det_match", det_match, expMatch[k]);
         checkOutput("busy_in_flight", busy, 1);
         if (k == 0) checkOutput("grant_id", grant_id, 0);
      end
      waitIdle();
      clrPulse();

      // Cross-word context on one stream
      applyStimulus(1'b0, 8'h0B, 1'b1, 0, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1, 1);
      waitIdle();
      clrPulse();

      // Interleaved streams keep separate contexts
      applyStimulus(1'b0, 8'h0B, 1'b1, 0, 0);
      applyStimulus(1'b1, 8'hFF, 1'b1, 0, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1, 1);
      waitIdle();

      // Simultaneous requests from reset alternate 0,1,0,1
      rst = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = '0; req1_data = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      nAcc = 0; guard = 0; prevCyc = 0;
      while (nAcc < 4 && guard < 80) begin
         @(negedge clk);
         guard++;
         if (req0_ready || req1_ready) begin
            exp_t ent;
            checkOutput("single_ready", req0_ready && req1_ready, 0);
            checkOutput("grant_order", req1_ready, nAcc % 2);
            if (nAcc > 0) checkOutput("accept_gap", cyc - prevCyc, W + 2);
            ent.id = req1_ready; ent.hits = 0; ent.total = 0; ent.acceptCyc = cyc;
            sbQ.push_back(ent);
            prevCyc = cyc;
            nAcc++;
         end
      end
      checkOutput("accept_count", nAcc, 4);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      waitIdle();
      clrPulse();

      // Abort mid-word clears counters and contexts
      applyStimulus(1'b0, 8'b10110110, 1'b1, 2, 2);
      waitIdle();
      applyStimulus(1'b0, 8'h0B, 1'b1, 0, 2);
      waitIdle();
      applyStimulus(1'b0, 8'b10110110, 1'b0, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dc = doneCount;
      clrPulse();
      repeat (12) @(negedge clk);
      checkOutput("abort_no_done", doneCount, dc);
      checkOutput("abort_match_cnt0", match_cnt0, 0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 8'h00, 1'b1, 0, 0);
      waitIdle();
      clrPulse();

      // Saturation on the CNT_W=2 instance
      applyStimulus(1'b0, 8'b10110110, 1'b1, 2, 2);
      waitIdle();
      checkOutput("sat_cnt_first", s_match_cnt0, 2);
      applyStimulus(1'b0, 8'b10110110, 1'b1, 2, 4);
      waitIdle();
      checkOutput("sat_cnt_saturated", s_match_cnt0, 3);
      checkOutput("scoreboard_drained", sbQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pattern_scan_arb.md
# pattern_scan_arb

Two-requester scheduler that time-shares a single serial Moore "10110" overlapping pattern detector. Each requester submits parallel words over a valid/ready handshake. The block arbitrates round-robin and serializes the granted word MSB-first through the detector. It saves and restores detector state per requester, so matches spanning word boundaries are found per stream, and it reports per-word hit counts plus running per-requester match totals.

## Interface
Parameters:
- WIDTH, 8, bits per submitted word (≥2)
- CNT_W, 8, width of running match counters and done_hits

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req0_valid  in  1  requester 0 word available
- req0_data  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&&ready
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1
- clr  in  1  synchronous clear/abort
- busy  out  1  word in flight (SHIFT or DONE)
- grant_id  out  1  requester owning current word
- det_bit  out  1  serial bit presented to detector this cycle
- det_match  out  1  Moore output, 1 while detector state is S5
- done_valid  out  1  one-cycle pulse, word finished
- done_id  out  1  requester of finished word
- done_hits  out  CNT_W  hits found in finished word
- match_cnt0, match_cnt1  out  CNT_W  running totals, saturating

## Operation
- Control FSM: IDLE → SHIFT (WIDTH cycles) → DONE (1 cycle) → IDLE.
- Arbitration (IDLE only):
  - Winner is the valid requester not equal to last_grant. If only one requester is valid, it wins.
  - req_ready_i = (ctrl==IDLE) && valid_i && winner==i. This is combinational, and at most one ready is high.
  - On handshake: capture data, set grant_id, update last_grant, load the detector from context[grant_id], clear the hit counter, go to SHIFT.
- Detector states are S0..S5, with S5 = "10110" seen. Transitions, written as state(input 0 / input 1):
  - S0(S0/S1)
  - S1(S2/S1)
  - S2(S0/S3)
  - S3(S2/S4)
  - S4(S5/S1)
  - S5(S0/S3)
  - Overlap is preserved by S5 on input 1 going to S3.
- SHIFT:
  - det_bit = word[WIDTH-1-k] in the k-th SHIFT cycle.
  - The detector advances every SHIFT cycle.
  - The hit counter increments when the next state is S5.
- DONE:
  - Write the detector state back to context[grant_id].
  - Pulse done_valid with done_id and done_hits.
  - Add the hits to match_cnt[grant_id], saturating at 2^CNT_W-1.
- The detector holds its state outside SHIFT. det_match reflects the held state.
- clr, in any state:
  - Next cycle: ctrl=IDLE, both contexts=S0, detector=S0, counters=0, last_grant=1.
  - No done_valid pulse for an aborted word.
  - Ready outputs are low in the cycle clr is high.
- Reset values: ctrl=IDLE, detector and both contexts=S0, last_grant=1 (requester 0 wins first), all outputs 0 (readys follow the IDLE rule once rst deasserts).

## Timing
- Handshake in cycle T:
  - SHIFT cycles are T+1..T+WIDTH. Bit k is presented in cycle T+1+k.
  - DONE is cycle T+WIDTH+1, with done_valid high in that cycle only.
  - IDLE is cycle T+WIDTH+2, where the next handshake is possible.
- Throughput: one word per WIDTH+2 cycles.
- busy = 1 in cycles T+1..T+WIDTH+1.
- det_match is registered and rises the cycle after the bit that completes the pattern.
- match_cnt updates are visible at T+WIDTH+2.
- Both requesters valid in the same IDLE cycle: the one not granted last wins. The loser keeps valid and is served next.
- Requester data may change once ready has been seen. The block uses only the captured copy.
- A requester dropping valid while not ready is legal and is ignored.
- rst low mid-word: immediate return to reset values. The word is lost, with no done pulse.

## Test plan
- Reset and idle:
  - Stimulus: hold rst=0 for 3 cycles, then release with no valids.
  - Required: all outputs 0, both readys 0, busy 0.
- Single word, overlapping hits:
  - Stimulus: req0 sends 8'b10110110, accepted at T.
  - Required: done_valid at T+9, done_id=0, done_hits=2, match_cnt0=2. det_match is high in the cycles after bit 4 and bit 7.
- Cross-word context:
  - Stimulus: req0 sends 8'h0B, then 8'h00.
  - Required: hits 0 then 1 (first bit of the second word completes the pattern), match_cnt0=1.
- Interleaved streams:
  - Stimulus: req0 sends 8'h0B, req1 sends 8'hFF, req0 sends 8'h00, arriving in that order.
  - Required: req1 done_hits=0, req0 second word done_hits=1, match_cnt1=0. req1 traffic does not disturb req0's context.
- Simultaneous requests:
  - Stimulus: both valid continuously from reset.
  - Required: grants alternate 0,1,0,1 with accepts WIDTH+2 cycles apart.
- Abort and saturation:
  - Stimulus: assert clr in the 4th SHIFT cycle.
  - Required: no done pulse, counters 0, contexts S0.
  - Stimulus: with CNT_W=2, send 8'b10110110 twice.
  - Required: match_cnt0 saturates at 3.
